// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with clear/load/enable priority, saturate-or-wrap bounds, cascade carry and a wrap pulse.
// Count and wrap pulse are registered (1-cycle); tc/co are combinational; there is no backpressure, so an input takes effect on every edge.
module counter_mod_updown #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = longint'(1) << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_enable,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count_ff,
    output logic             o_co,
    output logic             o_tc,
    output logic             o_wrap_ff
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_zero, load_in_range;

    assign at_max        = (count_q == MAX_VAL);
    assign at_zero       = (count_q == '0);
    // Zero-extend to 64 bits so the range test also holds when MODULUS is 2**32.
    assign load_in_range = ({{(64-WIDTH){1'b0}}, i_load_val} < MODULUS);

    assign o_tc       = i_up ? at_max : at_zero;
    assign o_co       = o_tc & i_enable & ~i_load & ~i_clear;
    assign o_count_ff = count_q;
    assign o_wrap_ff  = wrap_q;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = load_in_range ? i_load_val : MAX_VAL;
        end else if (i_enable) begin
            if (i_up) begin
                if (!at_max) begin
                    count_d = count_q + ONE;
                end else if (SATURATE != 0) begin
                    count_d = MAX_VAL;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - ONE;
                end else if (SATURATE != 0) begin
                    count_d = '0;
                end else begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Checks three single-digit configurations and a two-digit cascade against an arithmetic reference model.
module tb_counter_mod_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, ld, en, up, casc_en, casc_up, cmp_on;
    logic [3:0] lv;

    logic [3:0] d_cnt [3];
    logic       d_co [3];
    logic       d_tc [3];
    logic       d_wrap [3];

    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_co, lo_tc, lo_wrap, hi_co, hi_tc, hi_wrap;

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_m10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_load(ld), .i_load_val(lv),
        .i_enable(en), .i_up(up), .o_count_ff(d_cnt[0]), .o_co(d_co[0]),
        .o_tc(d_tc[0]), .o_wrap_ff(d_wrap[0]));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_load(ld), .i_load_val(lv),
        .i_enable(en), .i_up(up), .o_count_ff(d_cnt[1]), .o_co(d_co[1]),
        .o_tc(d_tc[1]), .o_wrap_ff(d_wrap[1]));

    counter_mod_updown #(.WIDTH(4), .SATURATE(0)) u_m16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_load(ld), .i_load_val(lv),
        .i_enable(en), .i_up(up), .o_count_ff(d_cnt[2]), .o_co(d_co[2]),
        .o_tc(d_tc[2]), .o_wrap_ff(d_wrap[2]));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_load(1'b0), .i_load_val(4'd0),
        .i_enable(casc_en), .i_up(casc_up), .o_count_ff(lo_cnt), .o_co(lo_co),
        .o_tc(lo_tc), .o_wrap_ff(lo_wrap));

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_load(1'b0), .i_load_val(4'd0),
        .i_enable(lo_co), .i_up(casc_up), .o_count_ff(hi_cnt), .o_co(hi_co),
        .o_tc(hi_tc), .o_wrap_ff(hi_wrap));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts are plain integers in 0..M-1.
    int mods [3] = '{10, 10, 16};
    bit sats [3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [3];
    bit m_wrap [3];
    int c_val;
    bit c_wrap;

    function automatic int advance(input int c, input bit u, input int m, input bit s);
        int r;
        r = u ? c + 1 : c - 1;
        if (r >= 0 && r < m) return r;
        if (s) return (r < 0) ? 0 : m - 1;
        return (r + m) % m;
    endfunction

    function automatic bit leaves_range(input int c, input bit u, input int m);
        return u ? (c + 1 >= m) : (c == 0);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clr) begin
                m_cnt[i]  <= 0;
                m_wrap[i] <= 1'b0;
            end else if (ld) begin
                m_cnt[i]  <= (int'(lv) < mods[i]) ? int'(lv) : mods[i] - 1;
                m_wrap[i] <= 1'b0;
            end else if (en) begin
                m_cnt[i]  <= advance(m_cnt[i], up, mods[i], sats[i]);
                m_wrap[i] <= !sats[i] && leaves_range(m_cnt[i], up, mods[i]);
            end else begin
                m_wrap[i] <= 1'b0;
            end
        end
        if (!rst_n) begin
            c_val  <= 0;
            c_wrap <= 1'b0;
        end else if (casc_en) begin
            c_val  <= casc_up ? (c_val + 1) % 100 : (c_val + 99) % 100;
            c_wrap <= casc_up ? (c_val == 99) : (c_val == 0);
        end else begin
            c_wrap <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                bit t;
                t = up ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
                chk($sformatf("cnt[%0d]", i), d_cnt[i], m_cnt[i]);
                chk($sformatf("wrap[%0d]", i), d_wrap[i], m_wrap[i]);
                chk($sformatf("tc[%0d]", i), d_tc[i], t);
                chk($sformatf("co[%0d]", i), d_co[i], t && en && !ld && !clr);
            end
            chk("casc_lo", lo_cnt, c_val % 10);
            chk("casc_hi", hi_cnt, c_val / 10);
            chk("casc_lo_co", lo_co, casc_en && (casc_up ? (c_val % 10 == 9) : (c_val % 10 == 0)));
            chk("casc_hi_co", hi_co, casc_en && (casc_up ? (c_val == 99) : (c_val == 0)));
            chk("casc_hi_wrap", hi_wrap, c_wrap);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b1; lv = 4'd0;
        casc_en = 1'b0; casc_up = 1'b1; cmp_on = 1'b0;
        tick();
        tick();
        cmp_on = 1'b1;

        // Reset state, with tc following the reset count in both directions.
        up = 1'b0;
        #1;
        chk("rst_cnt", d_cnt[0], 0);
        chk("rst_wrap", d_wrap[0], 0);
        chk("rst_tc_down", d_tc[0], 1);
        up = 1'b1;
        #1;
        chk("rst_tc_up", d_tc[0], 0);

        // Count up 0..9,0,1 with carry at 9 and wrap pulse after rollover.
        tick();
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("up_seq_cnt", d_cnt[0], k % 10);
            chk("up_seq_co", d_co[0], k == 9);
            chk("up_seq_wrap", d_wrap[0], k == 10);
            tick();
        end

        // Count down from 0: borrow at 0, then 9,8,7.
        clr = 1'b1;
        tick();
        clr = 1'b0; up = 1'b0;
        #1;
        chk("dn_cnt0", d_cnt[0], 0);
        chk("dn_co0", d_co[0], 1);
        tick(); #1; chk("dn_cnt9", d_cnt[0], 9); chk("dn_wrap9", d_wrap[0], 1);
        tick(); #1; chk("dn_cnt8", d_cnt[0], 8); chk("dn_wrap8", d_wrap[0], 0);
        tick(); #1; chk("dn_cnt7", d_cnt[0], 7);

        // Saturating instance held at 9.
        ld = 1'b1; lv = 4'd8; en = 1'b0;
        tick();
        ld = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("sat_cnt", d_cnt[1], 9);
            chk("sat_wrap", d_wrap[1], 0);
            chk("sat_co", d_co[1], 1);
        end

        // Out-of-range load clamps; clear beats load.
        en = 1'b0; ld = 1'b1; lv = 4'd13;
        tick(); #1;
        chk("ld13_m10", d_cnt[0], 9);
        chk("ld13_sat", d_cnt[1], 9);
        chk("ld13_m16", d_cnt[2], 13);
        clr = 1'b1; lv = 4'd5;
        tick(); #1;
        chk("clr_over_ld", d_cnt[0], 0);
        clr = 1'b0; ld = 1'b0;

        // One-cycle reset at count 7 while enabled, then resume 1,2.
        ld = 1'b1; lv = 4'd7;
        tick();
        ld = 1'b0; en = 1'b1; up = 1'b1; rst_n = 1'b0;
        #1; chk("pre_rst_cnt", d_cnt[0], 7);
        tick();
        rst_n = 1'b1;
        #1; chk("mid_rst_cnt", d_cnt[0], 0); chk("mid_rst_wrap", d_wrap[0], 0);
        tick(); #1; chk("resume_1", d_cnt[0], 1);
        tick(); #1; chk("resume_2", d_cnt[0], 2);

        // Reset on the edge that would have wrapped leaves no pulse.
        ld = 1'b1; lv = 4'd9; en = 1'b0;
        tick();
        ld = 1'b0; en = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b0;
        #1; chk("rst_at_wrap_cnt", d_cnt[0], 0); chk("rst_at_wrap_pulse", d_wrap[0], 0);

        // Two-digit cascade rolls 99 -> 00.
        casc_en = 1'b1; casc_up = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            chk("casc_seq_hi", hi_cnt, k / 10);
            chk("casc_seq_lo", lo_cnt, k % 10);
            chk("casc_seq_hi_co", hi_co, k == 99);
            tick();
        end
        #1;
        chk("casc_roll_hi", hi_cnt, 0);
        chk("casc_roll_lo", lo_cnt, 0);
        chk("casc_roll_wrap", hi_wrap, 1);

        // Randomized traffic against the model.
        repeat (3000) begin
            tick();
            rst_n   = ($urandom_range(0, 49) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            ld      = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            lv      = 4'($urandom);
            casc_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) casc_up = ~casc_up;
        end
        tick();
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
